// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the I2C master arbiter and its round-robin picker.
package i2c_arb_pkg;

    localparam int I2C_DATA_W = 256;
    localparam int I2C_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RETRY = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic                  rw;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_ADDR_W-1:0] port_f;
        logic [I2C_ADDR_W-1:0] port_s;
        logic [I2C_DATA_W-1:0] data;
    } i2c_desc_t;

endpackage

// File: rtl/i2c_master_arbiter_picker.sv
// i2c_rr_picker: combinational round-robin winner, searching upward from i_ptr+1 with wrap.
module i2c_rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % NREQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NREQ requesters.
// Define I2C_ARB_RETRY_EN to relaunch up to MAX_RETRY times after a master error.
module i2c_master_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int TIMEOUT   = 100000,
    parameter int MAX_RETRY = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NREQ-1:0]            i_req_valid,
    input  logic [NREQ-1:0]            i_req_rw,
    input  logic [I2C_ADDR_W*NREQ-1:0] i_req_addr,
    input  logic [I2C_ADDR_W*NREQ-1:0] i_req_port_f,
    input  logic [I2C_ADDR_W*NREQ-1:0] i_req_port_s,
    input  logic [I2C_DATA_W*NREQ-1:0] i_req_data,
    output logic [NREQ-1:0]            o_req_ack,
    output logic                       o_resp_valid,
    output logic [$clog2(NREQ)-1:0]    o_resp_id,
    output logic                       o_resp_err,
    output logic                       o_resp_timeout,
    output logic [I2C_DATA_W-1:0]      o_resp_data,
    output logic                       o_busy,
    output logic                       o_m_enable,
    output logic                       o_m_rw,
    output logic [I2C_ADDR_W-1:0]      o_m_addr,
    output logic [I2C_ADDR_W-1:0]      o_m_port_addr_f,
    output logic [I2C_ADDR_W-1:0]      o_m_port_addr_s,
    output logic [I2C_DATA_W-1:0]      o_m_data_in,
    input  logic                       i_m_done,
    input  logic                       i_m_err,
    input  logic [I2C_DATA_W-1:0]      i_m_data_out
);

    localparam int               IDX_W    = $clog2(NREQ);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NREQ - 1);

    arb_state_t             r_state, w_state;
    logic [IDX_W-1:0]       r_rr_ptr, w_rr_ptr;
    i2c_desc_t              r_desc, w_desc;
    logic                   r_m_enable, w_m_enable;
    logic [CNT_W-1:0]       r_cnt, w_cnt;
    logic [NREQ-1:0]        r_req_ack, w_req_ack;
    logic                   r_resp_valid, w_resp_valid;
    logic [IDX_W-1:0]       r_resp_id, w_resp_id;
    logic                   r_resp_err, w_resp_err;
    logic                   r_resp_timeout, w_resp_timeout;
    logic [I2C_DATA_W-1:0]  r_resp_data, w_resp_data;

    logic [NREQ-1:0]        w_grant_oh;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any;
    logic                   w_retry_ok;

`ifdef I2C_ARB_RETRY_EN
    localparam int          RETRY_W = $clog2(MAX_RETRY + 2);
    logic [RETRY_W-1:0]     r_retry, w_retry;
    assign w_retry_ok = (r_retry < RETRY_W'(MAX_RETRY));
`else
    // Retries compiled out: every master error is reported immediately.
    assign w_retry_ok = (MAX_RETRY < 0);
`endif

    i2c_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_grant_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_state        = r_state;
        w_rr_ptr       = r_rr_ptr;
        w_desc         = r_desc;
        w_m_enable     = r_m_enable;
        w_cnt          = r_cnt;
        w_req_ack      = '0;
        w_resp_valid   = 1'b0;
        w_resp_id      = '0;
        w_resp_err     = 1'b0;
        w_resp_timeout = 1'b0;
        w_resp_data    = '0;
`ifdef I2C_ARB_RETRY_EN
        w_retry        = r_retry;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_desc.rw     = i_req_rw[w_grant_idx];
                    w_desc.addr   = i_req_addr[int'(w_grant_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    w_desc.port_f = i_req_port_f[int'(w_grant_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    w_desc.port_s = i_req_port_s[int'(w_grant_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    w_desc.data   = i_req_data[int'(w_grant_idx)*I2C_DATA_W +: I2C_DATA_W];
                    w_req_ack     = w_grant_oh;
                    w_m_enable    = 1'b1;
                    w_cnt         = '0;
                    w_rr_ptr      = w_grant_idx;
                    w_state       = ST_WAIT;
`ifdef I2C_ARB_RETRY_EN
                    w_retry       = '0;
`endif
                end
            end
            ST_WAIT: begin
                // Error wins over done when both arrive together.
                if (i_m_err) begin
                    w_m_enable = 1'b0;
                    if (w_retry_ok) begin
                        w_state = ST_RETRY;
                    end else begin
                        w_state      = ST_RESP;
                        w_resp_valid = 1'b1;
                        w_resp_id    = r_rr_ptr;
                        w_resp_err   = 1'b1;
                    end
                end else if (i_m_done) begin
                    w_m_enable   = 1'b0;
                    w_state      = ST_RESP;
                    w_resp_valid = 1'b1;
                    w_resp_id    = r_rr_ptr;
                    w_resp_data  = r_desc.rw ? i_m_data_out : '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_m_enable     = 1'b0;
                    w_state        = ST_RESP;
                    w_resp_valid   = 1'b1;
                    w_resp_id      = r_rr_ptr;
                    w_resp_err     = 1'b1;
                    w_resp_timeout = 1'b1;
                end else if (r_cnt != '1) begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
`ifdef I2C_ARB_RETRY_EN
            ST_RETRY: begin
                w_retry    = r_retry + 1'b1;
                w_cnt      = '0;
                w_m_enable = 1'b1;
                w_state    = ST_WAIT;
            end
`endif
            ST_RESP: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= PTR_RST;
            r_desc         <= '0;
            r_m_enable     <= 1'b0;
            r_cnt          <= '0;
            r_req_ack      <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= '0;
            r_resp_err     <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_resp_data    <= '0;
`ifdef I2C_ARB_RETRY_EN
            r_retry        <= '0;
`endif
        end else begin
            r_state        <= w_state;
            r_rr_ptr       <= w_rr_ptr;
            r_desc         <= w_desc;
            r_m_enable     <= w_m_enable;
            r_cnt          <= w_cnt;
            r_req_ack      <= w_req_ack;
            r_resp_valid   <= w_resp_valid;
            r_resp_id      <= w_resp_id;
            r_resp_err     <= w_resp_err;
            r_resp_timeout <= w_resp_timeout;
            r_resp_data    <= w_resp_data;
`ifdef I2C_ARB_RETRY_EN
            r_retry        <= w_retry;
`endif
        end
    end

    assign o_req_ack       = r_req_ack;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_id       = r_resp_id;
    assign o_resp_err      = r_resp_err;
    assign o_resp_timeout  = r_resp_timeout;
    assign o_resp_data     = r_resp_data;
    assign o_busy          = (r_state != ST_IDLE);
    assign o_m_enable      = r_m_enable;
    assign o_m_rw          = r_desc.rw;
    assign o_m_addr        = r_desc.addr;
    assign o_m_port_addr_f = r_desc.port_f;
    assign o_m_port_addr_s = r_desc.port_s;
    assign o_m_data_in     = r_desc.data;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: transaction-level model plus directed tests.
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
    import i2c_arb_pkg::*;

    localparam int NREQ      = 4;
    localparam int TIMEOUT   = 50;
    localparam int MAX_RETRY = 2;
`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_ON  = 1'b1;
`else
    localparam bit RETRY_ON  = 1'b0;
`endif

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        req_valid, req_rw;
    logic [8*NREQ-1:0]      req_addr, req_port_f, req_port_s;
    logic [256*NREQ-1:0]    req_data;
    logic [NREQ-1:0]        o_req_ack;
    logic                   o_resp_valid, o_resp_err, o_resp_timeout, o_busy;
    logic [1:0]             o_resp_id;
    logic [255:0]           o_resp_data, o_m_data_in;
    logic                   o_m_enable, o_m_rw;
    logic [7:0]             o_m_addr, o_m_port_addr_f, o_m_port_addr_s;
    logic                   m_done, m_err;
    logic [255:0]           m_data_out;

    int n_checks = 0;
    int n_errors = 0;

    i2c_master_arbiter #(
        .NREQ(NREQ), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req_valid(req_valid), .i_req_rw(req_rw), .i_req_addr(req_addr),
        .i_req_port_f(req_port_f), .i_req_port_s(req_port_s), .i_req_data(req_data),
        .o_req_ack(o_req_ack), .o_resp_valid(o_resp_valid), .o_resp_id(o_resp_id),
        .o_resp_err(o_resp_err), .o_resp_timeout(o_resp_timeout), .o_resp_data(o_resp_data),
        .o_busy(o_busy), .o_m_enable(o_m_enable), .o_m_rw(o_m_rw), .o_m_addr(o_m_addr),
        .o_m_port_addr_f(o_m_port_addr_f), .o_m_port_addr_s(o_m_port_addr_s),
        .o_m_data_in(o_m_data_in),
        .i_m_done(m_done), .i_m_err(m_err), .i_m_data_out(m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int           cyc = 0;
    bit           live = 1'b0;
    int           mdl_ptr = NREQ - 1;
    int           win_start, retries;
    int           resp_cyc = -10, gap_cyc = -10;
    logic [3:0]   e_ack = '0;
    logic         e_en = 1'b0, e_rw = 1'b0, e_rv = 1'b0, e_rerr = 1'b0, e_rto = 1'b0, e_busy = 1'b0;
    logic [1:0]   e_rid = '0;
    logic [7:0]   e_addr = '0, e_pf = '0, e_ps = '0;
    logic [255:0] e_din = '0, e_rdata = '0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        cyc++;
        e_ack = '0; e_rv = 1'b0; e_rid = '0; e_rerr = 1'b0; e_rto = 1'b0; e_rdata = '0;
        if (reset) begin
            live = 1'b0; mdl_ptr = NREQ - 1; e_en = 1'b0;
            e_rw = 1'b0; e_addr = '0; e_pf = '0; e_ps = '0; e_din = '0;
            resp_cyc = -10; gap_cyc = -10;
        end else if (!live) begin
            w = pick(req_valid, mdl_ptr);
            if (w >= 0) begin
                live = 1'b1; mdl_ptr = w; e_ack[w] = 1'b1; e_en = 1'b1;
                win_start = cyc; retries = 0; resp_cyc = -10; gap_cyc = -10;
                e_rw = req_rw[w]; e_addr = req_addr[w*8 +: 8];
                e_pf = req_port_f[w*8 +: 8]; e_ps = req_port_s[w*8 +: 8];
                e_din = req_data[w*256 +: 256];
            end
        end else if (cyc - 1 == resp_cyc) begin
            live = 1'b0;
        end else if (cyc - 1 == gap_cyc) begin
            e_en = 1'b1; win_start = cyc; retries++;
        end else if (m_err && RETRY_ON && retries < MAX_RETRY) begin
            e_en = 1'b0; gap_cyc = cyc;
        end else if (m_err || m_done || (cyc - win_start == TIMEOUT)) begin
            e_en = 1'b0; resp_cyc = cyc; e_rv = 1'b1; e_rid = 2'(mdl_ptr);
            e_rerr = m_err || !m_done;
            e_rto = !m_err && !m_done;
            e_rdata = (!m_err && m_done && e_rw) ? m_data_out : '0;
        end
        e_busy = live;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("req_ack", o_req_ack, e_ack);
            chk("m_enable", o_m_enable, e_en);
            chk("m_rw", o_m_rw, e_rw);
            chk("m_addr", o_m_addr, e_addr);
            chk("m_port_f", o_m_port_addr_f, e_pf);
            chk("m_port_s", o_m_port_addr_s, e_ps);
            chk("m_data_in", o_m_data_in, e_din);
            chk("resp_valid", o_resp_valid, e_rv);
            chk("resp_id", o_resp_id, e_rid);
            chk("resp_err", o_resp_err, e_rerr);
            chk("resp_timeout", o_resp_timeout, e_rto);
            chk("resp_data", o_resp_data, e_rdata);
            chk("busy", o_busy, e_busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req_valid = req_valid & ~o_req_ack;
        end
    endtask

    task automatic post(input int id, input bit rw, input logic [7:0] a, input logic [7:0] pf,
                        input logic [7:0] ps, input logic [255:0] d);
        req_rw[id] = rw;
        req_addr[id*8 +: 8] = a;
        req_port_f[id*8 +: 8] = pf;
        req_port_s[id*8 +: 8] = ps;
        req_data[id*256 +: 256] = d;
        req_valid[id] = 1'b1;
    endtask

    task automatic wait_ack(output int id);
        id = -1;
        for (int n = 0; n < 20 && id < 0; n++) begin
            tick(1);
            for (int i = 0; i < NREQ; i++) if (o_req_ack[i]) id = i;
        end
        n_checks++;
        if (id < 0) begin
            n_errors++;
            $display("FAIL ack_wait: no req_ack within 20 cycles, expected a grant");
        end
    endtask

    task automatic finish_done();
        m_done = 1'b1; tick(1); m_done = 1'b0; tick(1);
    endtask

    int           id, n;
    int           grants[4];
    int           ack_at[4];
    logic [255:0] pat_a5;

    initial begin
        reset = 1'b1; req_valid = '0; req_rw = '0; req_addr = '0; req_port_f = '0;
        req_port_s = '0; req_data = '0; m_done = 1'b0; m_err = 1'b0; m_data_out = '0;
        pat_a5 = {32{8'hA5}};
        tick(3);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_enable", o_m_enable, 1'b0);
        chk("rst_ack", o_req_ack, 4'b0000);
        reset = 1'b0;

        // single write from requester 2
        post(2, 1'b0, 8'h55, 8'h02, 8'h02, {8{32'hC0DE_0002}});
        tick(1);
        chk("t1_ack", o_req_ack, 4'b0100);
        chk("t1_enable", o_m_enable, 1'b1);
        chk("t1_addr", o_m_addr, 8'h55);
        chk("t1_port_f", o_m_port_addr_f, 8'h02);
        chk("t1_data_in", o_m_data_in, {8{32'hC0DE_0002}});
        tick(2);
        m_done = 1'b1; tick(1); m_done = 1'b0;
        chk("t1_resp_valid", o_resp_valid, 1'b1);
        chk("t1_resp_id", o_resp_id, 2'd2);
        chk("t1_resp_err", o_resp_err, 1'b0);
        chk("t1_resp_data", o_resp_data, 256'd0);
        tick(1);

        // all four at once after reset: grant order 0,1,2,3 at 3-cycle spacing
        reset = 1'b1; tick(2); reset = 1'b0;
        for (int i = 0; i < NREQ; i++)
            post(i, 1'b0, 8'(8'h10 + i), 8'(i), 8'(i + 1), {8{32'(32'h1111_1111 * (i + 1))}});
        for (int g = 0; g < 4; g++) begin
            wait_ack(id);
            grants[g] = id; ack_at[g] = cyc;
            m_done = 1'b1; tick(1); m_done = 1'b0;
            chk("t2_gap_enable", o_m_enable, 1'b0);
            tick(1);
        end
        for (int g = 0; g < 4; g++) chk("t2_order", 256'(grants[g]), 256'(g));
        chk("t2_spacing", 256'(ack_at[1] - ack_at[0]), 256'd3);
        post(0, 1'b0, 8'h20, 8'h00, 8'h00, 256'd7);
        post(2, 1'b0, 8'h22, 8'h00, 8'h00, 256'd9);
        wait_ack(id);
        chk("t2_wrap_to_0", 256'(id), 256'd0);
        finish_done();
        wait_ack(id);
        chk("t2_then_2", 256'(id), 256'd2);
        finish_done();

        // read from requester 1
        post(1, 1'b1, 8'h3C, 8'h10, 8'h20, 256'd0);
        wait_ack(id);
        tick(1);
        m_data_out = pat_a5; m_done = 1'b1; tick(1); m_done = 1'b0;
        chk("t3_resp_data", o_resp_data, pat_a5);
        chk("t3_resp_err", o_resp_err, 1'b0);
        chk("t3_resp_id", o_resp_id, 2'd1);
        tick(1);

        // master silent: timeout after TIMEOUT enable cycles
        post(3, 1'b0, 8'h77, 8'h01, 8'h02, 256'd5);
        wait_ack(id);
        n = 0;
        while (o_m_enable === 1'b1 && n < 200) begin n++; tick(1); end
        chk("t4_window", 256'(n), 256'd50);
        chk("t4_resp_valid", o_resp_valid, 1'b1);
        chk("t4_resp_err", o_resp_err, 1'b1);
        chk("t4_resp_timeout", o_resp_timeout, 1'b1);
        tick(1);

        // master errors, including err+done together
        post(0, 1'b1, 8'h41, 8'h03, 8'h04, 256'd1);
        wait_ack(id);
        tick(2);
        m_err = 1'b1; tick(1); m_err = 1'b0;
`ifdef I2C_ARB_RETRY_EN
        chk("t5_gap1_enable", o_m_enable, 1'b0);
        chk("t5_gap1_resp", o_resp_valid, 1'b0);
        tick(1);
        chk("t5_relaunch1", o_m_enable, 1'b1);
        m_err = 1'b1; m_done = 1'b1; tick(1); m_err = 1'b0; m_done = 1'b0;
        chk("t5_gap2_enable", o_m_enable, 1'b0);
        chk("t5_gap2_resp", o_resp_valid, 1'b0);
        tick(1);
        chk("t5_relaunch2", o_m_enable, 1'b1);
        m_done = 1'b1; tick(1); m_done = 1'b0;
        chk("t5_ok_valid", o_resp_valid, 1'b1);
        chk("t5_ok_err", o_resp_err, 1'b0);
        chk("t5_ok_data", o_resp_data, pat_a5);
        tick(1);
        post(1, 1'b1, 8'h42, 8'h05, 8'h06, 256'd2);
        wait_ack(id);
        repeat (2) begin
            m_err = 1'b1; tick(1); m_err = 1'b0; tick(1);
        end
        m_err = 1'b1; tick(1); m_err = 1'b0;
        chk("t5_exhaust_valid", o_resp_valid, 1'b1);
        chk("t5_exhaust_err", o_resp_err, 1'b1);
        chk("t5_exhaust_data", o_resp_data, 256'd0);
`else
        chk("t5_err_valid", o_resp_valid, 1'b1);
        chk("t5_err_err", o_resp_err, 1'b1);
        chk("t5_err_timeout", o_resp_timeout, 1'b0);
`endif
        tick(1);

        // reset in WAIT drops the transaction; next grant to requester 0
        post(2, 1'b0, 8'h66, 8'h07, 8'h08, 256'd3);
        wait_ack(id);
        tick(3);
        reset = 1'b1; tick(1);
        chk("t6_enable", o_m_enable, 1'b0);
        chk("t6_busy", o_busy, 1'b0);
        chk("t6_resp_valid", o_resp_valid, 1'b0);
        chk("t6_addr", o_m_addr, 8'h00);
        chk("t6_data_in", o_m_data_in, 256'd0);
        reset = 1'b0;
        post(3, 1'b0, 8'h13, 8'h00, 8'h00, 256'd13);
        post(0, 1'b0, 8'h10, 8'h00, 8'h00, 256'd10);
        wait_ack(id);
        chk("t6_first_grant", 256'(id), 256'd0);
        finish_done();
        wait_ack(id);
        chk("t6_second_grant", 256'(id), 256'd3);
        finish_done();

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: run still active at 200000 ns, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
